// File: rtl/seven_seg_mux.sv
// seven_seg_mux: two-digit multiplexed driver for a common-anode 7-seg display.
// Ports: clk, reset (sync, active-high), val[7:0] hex digits in;
//   an[1:0] anodes (active-low), seg[6:0] {g..a} (active-low), frame_tick.
// Optional macro LEADING_ZERO_BLANK_EN darkens a zero high digit.
module seven_seg_mux #(
  parameter int ON_CYCLES   = 24000,
  parameter int DEAD_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] val,
  output logic [1:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  generate
    if (ON_CYCLES < 1 || DEAD_CYCLES < 1) begin : g_bad_param
      $error("seven_seg_mux: ON_CYCLES and DEAD_CYCLES must be >= 1");
    end
  endgenerate

  localparam int MAXC = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES
                                                  : DEAD_CYCLES;
  localparam int W = $clog2(MAXC + 1);

  localparam logic [W-1:0] ON_LAST   = W'(ON_CYCLES - 1);
  localparam logic [W-1:0] DEAD_LAST = W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK_B,
    SHOW_LO,
    BLANK_A,
    SHOW_HI
  } state_t;

  state_t     state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic [7:0] snap, snap_nx;
  logic [1:0] an_nx;
  logic [6:0] seg_nx;
  logic       tick_nx;
  logic       hi_dark;

  function automatic logic [6:0] dec(input logic [3:0] d);
    unique case (d)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  endfunction

  // State, counter, snapshot and the registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK_B;
      cnt        <= '0;
      snap       <= 8'h00;
      an         <= 2'b11;
      seg        <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      snap       <= snap_nx;
      an         <= an_nx;
      seg        <= seg_nx;
      frame_tick <= tick_nx;
    end
  end

  // Next state and duration counter.
  always_comb begin
    logic done;
    done     = 1'b0;
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    unique case (state)
      BLANK_B: done = (cnt == DEAD_LAST);
      SHOW_LO: done = (cnt == ON_LAST);
      BLANK_A: done = (cnt == DEAD_LAST);
      default: done = (cnt == ON_LAST);
    endcase
    if (done) begin
      cnt_nx   = '0;
      state_nx = state_t'(state + 2'd1);
    end
  end

  // Outputs are computed from the upcoming state so the registers
  // change on the same edge as the state itself.
  always_comb begin
    tick_nx = (state_nx == SHOW_LO) && (state != SHOW_LO);
    snap_nx = tick_nx ? val : snap;
`ifdef LEADING_ZERO_BLANK_EN
    hi_dark = (snap_nx[7:4] == 4'h0);
`else
    hi_dark = 1'b0;
`endif
    an_nx  = 2'b11;
    seg_nx = 7'h7F;
    unique case (state_nx)
      SHOW_LO: begin
        an_nx  = 2'b10;
        seg_nx = dec(snap_nx[3:0]);
      end
      SHOW_HI: begin
        if (!hi_dark) begin
          an_nx  = 2'b01;
          seg_nx = dec(snap_nx[7:4]);
        end
      end
      default: begin
        an_nx  = 2'b11;
        seg_nx = 7'h7F;
      end
    endcase
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: directed bench for seven_seg_mux, ON=4, DEAD=2.
// Frame-position model with hand-written decode table.
module tb_seven_seg_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] val;
  logic [1:0] an;
  logic [6:0] seg;
  logic       frame_tick;

  int asserts = 0;
  int fails   = 0;
  int n;
  logic [7:0] snap_m;

  seven_seg_mux #(
    .ON_CYCLES  (4),
    .DEAD_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .val       (val),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_t [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  task automatic check_model();
    int p;
    logic [1:0] ea;
    logic [6:0] es;
    logic       et;
    logic       dark;
    p  = n % 12;
    ea = 2'b11;
    es = 7'h7F;
    et = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    dark = (snap_m[7:4] == 4'h0);
`else
    dark = 1'b0;
`endif
    if (p >= 2 && p <= 5) begin
      ea = 2'b10;
      es = dec_t[snap_m[3:0]];
      et = (p == 2);
    end else if (p >= 8 && !dark) begin
      ea = 2'b01;
      es = dec_t[snap_m[7:4]];
    end
    check("an", 8'(an), 8'(ea));
    check("seg", 8'(seg), 8'(es));
    check("tick", 8'(frame_tick), 8'(et));
    check("an_ne00", 8'(an == 2'b00), 8'h00);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      n++;
      if (n % 12 == 2) snap_m = val;
      @(posedge clk);
      #1;
      check_model();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_an", 8'(an), 8'h03);
      check("rst_seg", 8'(seg), 8'h7F);
      check("rst_tick", 8'(frame_tick), 8'h00);
    end
    reset  = 1'b0;
    n      = 0;
    snap_m = 8'h00;
    check_model();
  endtask

  initial begin
    n   = 0;
    val = 8'h3A;
    do_reset();
    run(26);

    val = 8'h12;
    do_reset();
    run(3);
    val = 8'h34;
    run(20);

    val = 8'h3A;
    do_reset();
    run(9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_an", 8'(an), 8'h03);
    check("abort_seg", 8'(seg), 8'h7F);
    check("abort_tick", 8'(frame_tick), 8'h00);
    reset  = 1'b0;
    n      = 0;
    snap_m = 8'h00;
    check_model();
    run(4);

    for (int d = 0; d < 16; d++) begin
      val = {4'(d), 4'(15 - d)};
      run(12);
    end

    val = 8'h07;
    run(12);
    val = 8'h00;
    run(12);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
